edge_acc_v2_0: RTL and testbench

EDGE_ACC_V2_0 -- requirements
Module: edge_acc_v2_0

---
 rtl/edge_acc_pkg.sv | 18 +
 rtl/edge_acc_v2_0_word_mux.sv | 29 ++
 rtl/edge_acc_v2_0.sv | 173 +++++++++++++++++
 tb/tb_edge_acc_v2_0.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_acc_pkg.sv
// Shared definitions for the edge accumulator.
//   dump_state_t : dump-stream FSM states
//   addr_width() : clog2-based address width for a word count (minimum 1)
package edge_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } dump_state_t;

    // Address width for n words; never less than 1 so a single-word
    // configuration still has a legal address port.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_acc_v2_0_word_mux.sv
// Word selector over the flat accumulator vector.
//   acc  : flat accumulator, word i at [i*WORD_W +: WORD_W]
//   addr : word address
//   word : selected word, 0 when addr >= NWORDS
module edge_word_mux
    import edge_acc_pkg::*;
#(
    parameter int ACC_W  = 4096,
    parameter int WORD_W = 32,
    parameter int NWORDS = 128,
    parameter int AW     = 7
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [AW-1:0]     addr,
    output logic [WORD_W-1:0] word
);

    // Address decode as an explicit compare per word: any address with no
    // matching word leaves the default zero in place.
    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            if (addr == AW'(i)) begin
                word = acc[i*WORD_W +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/edge_acc_v2_0.sv
// Sticky edge-mask accumulator with random word reads and a dump stream.
//   CLK, RST        : clock, synchronous active-high reset
//   mask_in/vld     : edge mask ORed into the accumulator when qualified
//   clr             : clear accumulator (a same-cycle mask is kept), aborts dump
//   xyz_in/xyz_out  : coordinate word, registered pass-through
//   rd_en/rd_addr   : random word read; rd_data/rd_vld one cycle later
//   dump_start      : stream every word on out_data/out_idx/out_last/out_vld,
//                     handshaked with out_rdy; busy high while dumping
module edge_acc_v2_0
    import edge_acc_pkg::*;
#(
    parameter int  LANES  = 8,
    parameter int  LANE_W = 512,
    parameter int  WORD_W = 32,
    parameter int  XYZ_W  = 14,
    localparam int NWORDS = LANES * LANE_W / WORD_W,
    localparam int AW     = addr_width(NWORDS)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [LANES*LANE_W-1:0] mask_in,
    input  logic                    mask_vld,
    input  logic                    clr,
    input  logic [XYZ_W-1:0]        xyz_in,
    output logic [XYZ_W-1:0]        xyz_out,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    output logic [WORD_W-1:0]       rd_data,
    output logic                    rd_vld,
    input  logic                    dump_start,
    output logic [WORD_W-1:0]       out_data,
    output logic [AW-1:0]           out_idx,
    output logic                    out_last,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic                    busy
);

    localparam int ACC_W = LANES * LANE_W;

    logic [ACC_W-1:0]  acc;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] dump_word;
    logic [AW-1:0]     idx;
    dump_state_t       state;

    // ---------------------------------------------------------------
    // Accumulator: clr wins over the sticky OR, but a mask qualified in
    // the same cycle survives the clear.
    // ---------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc <= '0;
        end else if (clr) begin
            acc <= mask_vld ? mask_in : '0;
        end else if (mask_vld) begin
            acc <= acc | mask_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            xyz_out <= '0;
        end else begin
            xyz_out <= xyz_in;
        end
    end

    // ---------------------------------------------------------------
    // Random read port, independent of the dump FSM. Returns the word as
    // it was before the same edge's accumulator update.
    // ---------------------------------------------------------------
    edge_word_mux #(
        .ACC_W  (ACC_W),
        .WORD_W (WORD_W),
        .NWORDS (NWORDS),
        .AW     (AW)
    ) u_rd_mux (
        .acc  (acc),
        .addr (rd_addr),
        .word (rd_word)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

    // ---------------------------------------------------------------
    // Dump stream
    // ---------------------------------------------------------------
    edge_word_mux #(
        .ACC_W  (ACC_W),
        .WORD_W (WORD_W),
        .NWORDS (NWORDS),
        .AW     (AW)
    ) u_dump_mux (
        .acc  (acc),
        .addr (idx),
        .word (dump_word)
    );

    // busy is registered alongside the state so it is high exactly while
    // the FSM sits in LOAD or SEND. clr is checked ahead of the handshake,
    // so an aborted SEND never completes a transfer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            idx      <= '0;
            out_data <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
            out_vld  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    out_vld <= 1'b0;
                    if (dump_start) begin
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (clr) begin
                        out_vld <= 1'b0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        out_data <= dump_word;
                        out_idx  <= idx;
                        out_last <= (idx == AW'(NWORDS - 1));
                        out_vld  <= 1'b1;
                        state    <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (clr) begin
                        out_vld <= 1'b0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (out_vld && out_rdy) begin
                        out_vld <= 1'b0;
                        if (out_last) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_LOAD;
                        end
                    end
                end

                default: begin
                    out_vld <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_acc_v2_0.sv
// Directed self-checking bench for edge_acc_v2_0 at default parameters.
module tb_edge_acc_v2_0;

    localparam int LANES  = 8;
    localparam int LANE_W = 512;
    localparam int WORD_W = 32;
    localparam int XYZ_W  = 14;
    localparam int NWORDS = 128;
    localparam int AW     = 7;
    localparam int MW     = LANES * LANE_W;

    logic              CLK = 1'b0;
    logic              RST;
    logic [MW-1:0]     mask_in;
    logic              mask_vld;
    logic              clr;
    logic [XYZ_W-1:0]  xyz_in;
    logic [XYZ_W-1:0]  xyz_out;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              rd_vld;
    logic              dump_start;
    logic [WORD_W-1:0] out_data;
    logic [AW-1:0]     out_idx;
    logic              out_last;
    logic              out_vld;
    logic              out_rdy;
    logic              busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [NWORDS];

    edge_acc_v2_0 #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .WORD_W (WORD_W),
        .XYZ_W  (XYZ_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .mask_in    (mask_in),
        .mask_vld   (mask_vld),
        .clr        (clr),
        .xyz_in     (xyz_in),
        .xyz_out    (xyz_out),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_vld     (rd_vld),
        .dump_start (dump_start),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NWORDS; i++) model[i] = '0;
    endtask

    task automatic do_read(input int a, input logic [31:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        tick();
        rd_en = 1'b0;
        chk({tag, "_vld"}, 64'(rd_vld), 64'd1);
        chk(tag, 64'(rd_data), 64'(exp));
    endtask

    // Full dump. toggle=0: out_rdy held high, 256-cycle budget checked and a
    // stray dump_start issued mid-dump. toggle=1: out_rdy alternates, hold
    // stability is checked and random reads run alongside the stream.
    task automatic run_dump(input string tag, input bit toggle);
        int          e, cyc;
        bit          pvld, pxfer, ppend, xfer;
        logic [AW-1:0] pidx, paddr;
        logic [31:0] pdata;
        e = 0; cyc = 0; pvld = 0; pxfer = 0; ppend = 0;
        pidx = '0; paddr = '0; pdata = '0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        while (busy && cyc < 2000) begin
            if (toggle) begin
                if (ppend) begin
                    chk({tag, "_rd_vld"}, 64'(rd_vld), 64'd1);
                    chk({tag, "_rd_data"}, 64'(rd_data), 64'(model[paddr]));
                end
                rd_en   = 1'b1;
                rd_addr = AW'(cyc);
                paddr   = rd_addr;
                ppend   = 1'b1;
            end
            if (pvld && !pxfer) begin
                chk({tag, "_hold_vld"}, 64'(out_vld), 64'd1);
                chk({tag, "_hold_idx"}, 64'(out_idx), 64'(pidx));
                chk({tag, "_hold_data"}, 64'(out_data), 64'(pdata));
            end
            out_rdy = toggle ? ~cyc[0] : 1'b1;
            xfer = out_vld && out_rdy;
            if (xfer) begin
                chk({tag, "_idx"}, 64'(out_idx), 64'(e));
                chk({tag, "_data"}, 64'(out_data), 64'(model[e]));
                chk({tag, "_last"}, 64'(out_last), (e == NWORDS - 1) ? 64'd1 : 64'd0);
                e++;
            end
            if (!toggle) dump_start = (cyc == 100);
            pvld = out_vld; pxfer = xfer; pidx = out_idx; pdata = out_data;
            tick();
            cyc++;
        end
        rd_en = 1'b0;
        dump_start = 1'b0;
        out_rdy = 1'b1;
        chk({tag, "_count"}, 64'(e), 64'(NWORDS));
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_vld_end"}, 64'(out_vld), 64'd0);
        if (!toggle) chk({tag, "_cycles"}, 64'(cyc), 64'd256);
    endtask

    initial begin
        int n;
        RST = 1'b1; mask_in = '0; mask_vld = 1'b0; clr = 1'b0; xyz_in = '0;
        rd_en = 1'b0; rd_addr = '0; dump_start = 1'b0; out_rdy = 1'b1;
        clear_model();
        tick();
        tick();
        chk("rst_rd_vld",   64'(rd_vld),   64'd0);
        chk("rst_rd_data",  64'(rd_data),  64'd0);
        chk("rst_out_vld",  64'(out_vld),  64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_idx",  64'(out_idx),  64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_xyz",      64'(xyz_out),  64'd0);
        RST = 1'b0;
        tick();

        // Coordinate pass-through latency
        xyz_in = 14'h0123;
        chk("xyz_before", 64'(xyz_out), 64'd0);
        tick();
        chk("xyz_latency", 64'(xyz_out), 64'h0123);

        // Lane0 bit0, then lane7 bit511
        mask_vld = 1'b1;
        mask_in = '0; mask_in[0] = 1'b1;
        tick();
        mask_in = '0; mask_in[MW-1] = 1'b1;
        tick();
        mask_vld = 1'b0; mask_in = '0;
        do_read(0,   32'h0000_0001, "rd_w0");
        do_read(127, 32'h8000_0000, "rd_w127");
        do_read(1,   32'h0000_0000, "rd_w1");
        tick();
        chk("rd_vld_idle",  64'(rd_vld),  64'd0);
        chk("rd_data_hold", 64'(rd_data), 64'd0);

        // clr together with mask_vld keeps only the new mask
        clr = 1'b1; mask_vld = 1'b1;
        mask_in = '0; mask_in[5*WORD_W +: WORD_W] = 32'hA5A5_A5A5;
        tick();
        clr = 1'b0; mask_vld = 1'b0; mask_in = '0;
        clear_model();
        model[5] = 32'hA5A5_A5A5;
        for (int a = 0; a < NWORDS; a++) do_read(a, model[a], $sformatf("rd_clr_%0d", a));

        // Sticky OR
        mask_vld = 1'b1;
        mask_in = '0; mask_in[5*WORD_W +: WORD_W] = 32'h0000_FFFF;
        tick();
        model[5] = 32'hA5A5_FFFF;
        // Read sees the value before the same edge's update
        mask_in = '0; mask_in[6*WORD_W +: WORD_W] = 32'h1234_5678;
        rd_en = 1'b1; rd_addr = 7'd6;
        tick();
        rd_en = 1'b0; mask_vld = 1'b0; mask_in = '0;
        model[6] = 32'h1234_5678;
        chk("rd_pre_update", 64'(rd_data), 64'd0);
        do_read(6, 32'h1234_5678, "rd_w6");
        do_read(5, 32'hA5A5_FFFF, "rd_w5_sticky");

        // Full-rate dump, then backpressured dump with concurrent reads
        run_dump("dump_full", 1'b0);
        tick();
        run_dump("dump_bp", 1'b1);
        tick();

        // clr abort at index 40
        out_rdy = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        n = 0;
        while (!(out_vld && out_idx == 7'd40) && n < 500) begin
            tick();
            n++;
        end
        chk("abort_reach_idx", 64'(out_idx), 64'd40);
        out_rdy = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        clear_model();
        chk("abort_vld",  64'(out_vld), 64'd0);
        chk("abort_busy", 64'(busy),    64'd0);
        out_rdy = 1'b1;
        tick();
        tick();
        chk("abort_vld_stays", 64'(out_vld), 64'd0);
        chk("abort_idle",      64'(busy),    64'd0);
        run_dump("dump_zero", 1'b0);
        tick();

        // Reset at index 10 mid-dump, overriding other inputs
        mask_vld = 1'b1;
        mask_in = '0; mask_in[3*WORD_W +: WORD_W] = 32'hDEAD_BEEF;
        tick();
        mask_vld = 1'b0; mask_in = '0;
        xyz_in = 14'h1ABC;
        tick();
        chk("xyz_pre_rst", 64'(xyz_out), 64'h1ABC);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        n = 0;
        while (!(out_vld && out_idx == 7'd10) && n < 500) begin
            tick();
            n++;
        end
        chk("rst_reach_idx", 64'(out_idx), 64'd10);
        RST = 1'b1; rd_en = 1'b1; rd_addr = 7'd3; mask_vld = 1'b1; mask_in = '1;
        dump_start = 1'b1; clr = 1'b0;
        tick();
        chk("mid_rst_vld",    64'(out_vld), 64'd0);
        chk("mid_rst_busy",   64'(busy),    64'd0);
        chk("mid_rst_xyz",    64'(xyz_out), 64'd0);
        chk("mid_rst_rd_vld", 64'(rd_vld),  64'd0);
        chk("mid_rst_idx",    64'(out_idx), 64'd0);
        tick();
        chk("mid_rst_xyz_hold", 64'(xyz_out), 64'd0);
        RST = 1'b0; rd_en = 1'b0; mask_vld = 1'b0; mask_in = '0; dump_start = 1'b0;
        tick();
        chk("post_rst_xyz",    64'(xyz_out), 64'h1ABC);
        chk("post_rst_vld",    64'(out_vld), 64'd0);
        chk("post_rst_rd_vld", 64'(rd_vld),  64'd0);
        tick();
        tick();
        chk("post_rst_no_xfer", 64'(out_vld), 64'd0);
        chk("post_rst_busy",    64'(busy),    64'd0);
        do_read(3, 32'h0, "post_rst_acc_w3");
        do_read(0, 32'h0, "post_rst_acc_w0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
